// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding and the STEP/width legality check.
package rv_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic bit step_legal(input int step, input int width);
    return ((step == 1) || (step == 2) || (step == 4)) && (width > 0) &&
           ((width % step) == 0);
  endfunction

endpackage

// File: rtl/rv_mul_step.sv
// Combinational radix-2^STEP partial-product step: adds multiplicand*digit
// into the upper half of the product register and shifts right by STEP.
module rv_mul_step #(
  parameter int DPWIDTH = 32,
  parameter int STEP    = 1
) (
  input  logic [2*DPWIDTH-1:0] prod_i,
  input  logic [DPWIDTH-1:0]   mcand_i,
  input  logic [STEP-1:0]      digit_i,
  output logic [2*DPWIDTH-1:0] prod_o
);

  logic [DPWIDTH+STEP-1:0] pp;
  logic [DPWIDTH+STEP-1:0] sum;

  // sum cannot overflow DPWIDTH+STEP bits: hi < 2^W and pp <= (2^W-1)(2^STEP-1)
  always_comb begin
    pp     = (DPWIDTH+STEP)'(mcand_i) * (DPWIDTH+STEP)'(digit_i);
    sum    = (DPWIDTH+STEP)'(prod_i[2*DPWIDTH-1:DPWIDTH]) + pp;
    prod_o = {sum, prod_i[DPWIDTH-1:STEP]};
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (IDLE -> CALC -> FIX -> DONE).
// Define RV_MULDIV_DIV_EN to build the restoring divider; otherwise ops 4-7 return 0.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int DPWIDTH = 32,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DPWIDTH-1:0] opa,
  input  logic [DPWIDTH-1:0] opb,
  output logic               busy,
  output logic               done,
  output logic [DPWIDTH-1:0] result
);

  localparam int W       = DPWIDTH;
  localparam int MUL_CYC = DPWIDTH / STEP;
  localparam int CW      = $clog2(DPWIDTH + 1);

  if (!step_legal(STEP, DPWIDTH)) begin : g_bad_cfg
    $error("rv_muldiv_unit: STEP must be 1, 2 or 4 and divide DPWIDTH");
  end

  function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;

  logic           accept;
  logic           a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] mul_next;
  logic [2*W-1:0] prod_fixed;

  rv_mul_step #(
    .DPWIDTH (DPWIDTH),
    .STEP    (STEP)
  ) u_mul_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .digit_i (prod_q[STEP-1:0]),
    .prod_o  (mul_next)
  );

`ifdef RV_MULDIV_DIV_EN
  logic [W:0] rem_sh, rem_sub;
  logic       div_by_zero, div_ovf;

  always_comb begin
    rem_sh      = {prod_q[2*W-1:W], prod_q[W-1]};
    rem_sub     = rem_sh - {1'b0, mcand_q};
    div_by_zero = (opb == '0);
    div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                  (opa == {1'b1, {(W-1){1'b0}}}) && (opb == '1);
  end
`endif

  always_comb begin
    accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && opa[W-1];
    b_neg    = b_signed && opb[W-1];
    a_mag    = cond_neg_w(opa, a_neg);
    b_mag    = cond_neg_w(opb, b_neg);
  end

  // Next state and datapath; the division special cases bypass CALC entirely
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    prod_fixed = cond_neg_2w(prod_q, neg_q);

    if (accept) begin
      op_d  = op;
      cnt_d = '0;
      if (op[2]) begin
`ifdef RV_MULDIV_DIV_EN
        mcand_d = b_mag;
        if (div_by_zero) begin
          prod_d  = {opa, {W{1'b1}}};
          neg_d   = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end else if (div_ovf) begin
          prod_d  = {{W{1'b0}}, opa};
          neg_d   = 1'b0;
          rneg_d  = 1'b0;
          state_d = S_FIX;
        end else begin
          prod_d  = {{W{1'b0}}, a_mag};
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          state_d = S_CALC;
        end
`else
        mcand_d = '0;
        prod_d  = '0;
        neg_d   = 1'b0;
        rneg_d  = 1'b0;
        state_d = S_FIX;
`endif
      end else begin
        mcand_d = a_mag;
        prod_d  = {{W{1'b0}}, b_mag};
        neg_d   = a_neg ^ b_neg;
        rneg_d  = 1'b0;
        state_d = S_CALC;
      end
    end else begin
      case (state_q)
        S_CALC: begin
          cnt_d = cnt_q + 1'b1;
`ifdef RV_MULDIV_DIV_EN
          if (op_q[2]) begin
            if (!rem_sub[W])
              prod_d = {rem_sub[W-1:0], prod_q[W-2:0], 1'b1};
            else
              prod_d = {rem_sh[W-1:0], prod_q[W-2:0], 1'b0};
            if (cnt_q == CW'(W - 1)) state_d = S_FIX;
          end else begin
            prod_d = mul_next;
            if (cnt_q == CW'(MUL_CYC - 1)) state_d = S_FIX;
          end
`else
          prod_d = mul_next;
          if (cnt_q == CW'(MUL_CYC - 1)) state_d = S_FIX;
`endif
        end
        S_FIX: begin
          case (op_q)
            OP_MUL:                      result_d = prod_fixed[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fixed[2*W-1:W];
            OP_DIV, OP_DIVU:             result_d = cond_neg_w(prod_q[W-1:0], neg_q);
            default:                     result_d = cond_neg_w(prod_q[2*W-1:W], rneg_q);
          endcase
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit (DPWIDTH=32, STEP=2); expectations adapt
// to whether RV_MULDIV_DIV_EN is defined.
module tb_rv_muldiv_unit;

  localparam int W   = 32;
  localparam int STP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  opa, opb;
  logic          busy, done;
  logic [W-1:0]  result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  rv_muldiv_unit #(.DPWIDTH(W), .STEP(STP)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu;
    logic [63:0]        p;
    logic signed [31:0] a32, b32;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'b0, b};
    a32 = a;
    b32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (o)
      3'd0: begin p = sa * sb;             model = p[31:0];  end
      3'd1: begin p = sa * sb;             model = p[63:32]; end
      3'd2: begin p = sa * sbu;            model = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; model = p[63:32]; end
`ifdef RV_MULDIV_DIV_EN
      3'd4: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : a32 / b32;
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: model = (b == 0) ? a : ovf ? 32'd0 : a32 % b32;
      3'd7: model = (b == 0) ? a : a % b;
`endif
      default: model = '0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return W / STP + 2;
`ifdef RV_MULDIV_DIV_EN
    if (b == 0) return 2;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return W + 2;
`else
    return 2;
`endif
  endfunction

  // Drive one request; caller guarantees the unit is IDLE or in DONE
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input string tag, input bit push);
    exp_t e;
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e.tag = tag; e.res = res; e.acc = cyc; e.lat = lat;
      sbq.push_back(e);
    end
  endtask

  task automatic issue_m(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    issue(o, a, b, model(o, a, b), exp_lat(o, a, b), tag, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    if (n >= 200) begin
      check("timeout_pending", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        check(sbq[0].tag, 64'(result), 64'(sbq[0].res));
        check({sbq[0].tag, "_lat"}, 64'(cyc - sbq[0].acc + 1), 64'(sbq[0].lat));
        check({sbq[0].tag, "_busy"}, 64'(busy_cnt), 64'(sbq[0].lat - 1));
        void'(sbq.pop_front());
      end
      busy_cnt <= 0;
    end else if (busy) begin
      busy_cnt <= busy_cnt + 1;
    end
  end

  logic [31:0] vals [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                            32'h7FFF_FFFF, 32'h3, 32'hFFFF_FFF9, 32'h1234_5678};

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 18, "mul_7x-3", 1'b1);
    wait_idle();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18, "mulh_min", 1'b1);
    wait_idle();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18, "mulhu_max", 1'b1);
    wait_idle();
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 18, "mulhsu_m1", 1'b1);
    wait_idle();

`ifdef RV_MULDIV_DIV_EN
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2", 1'b1);
    wait_idle();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2", 1'b1);
    wait_idle();
    issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0", 1'b1);
    wait_idle();
    issue(3'd7, 32'd5, 32'd0, 32'd5, 2, "remu_by0", 1'b1);
    wait_idle();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf", 1'b1);
    wait_idle();
    issue(3'd4, 32'd10, 32'd3, 32'd3, 34, "div_10_3", 1'b1);
    wait_idle();
`else
    issue(3'd4, 32'd10, 32'd3, 32'd0, 2, "div_off", 1'b1);
    wait_idle();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'd0, 2, "rem_off", 1'b1);
    wait_idle();
`endif
    issue(3'd0, 32'd10, 32'd3, 32'd30, 18, "mul_10x3", 1'b1);
    wait_idle();

    // start pulsed mid-CALC with different operands must be ignored
    issue(3'd0, 32'd123, 32'd456, 32'd56088, 18, "mul_ign", 1'b1);
    repeat (5) @(posedge clk);
    #1;
    op = 3'd3; opa = 32'hFFFF_FFFF; opb = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // start held in the DONE cycle is accepted back-to-back
    issue(3'd0, 32'd3, 32'd5, 32'd15, 18, "b2b_a", 1'b1);
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) break;
      end
      check("b2b_done_seen", 64'(done), 64'd1);
    end
    issue(3'd0, 32'hFFFF_FFFC, 32'd6, 32'hFFFF_FFE8, 18, "b2b_b", 1'b1);
    wait_idle();

    // reset in the middle of a multiply aborts it
    issue(3'd0, 32'd9, 32'd9, 32'd81, 18, "rst_victim", 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue(3'd0, 32'd9, 32'd9, 32'd81, 18, "after_rst", 1'b1);
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = (i % 2 == 0) ? vals[$urandom_range(0, 7)] : $urandom;
      rb = (i % 3 == 0) ? vals[$urandom_range(0, 7)] : $urandom;
      issue_m(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
